// File: rtl/video_timing_pkg.sv
// Shared derived-constant helpers for the raster timing blocks.
// Display-controller blocks import the same package so their porch/sync
// arithmetic always agrees with the generator's.
package video_timing_pkg;

  // Total positions on one axis: display + front porch + sync + back porch.
  function automatic int vt_total(input int display, input int front,
                                  input int sync, input int back);
    return display + front + sync + back;
  endfunction

  // Last position on an axis.
  function automatic int vt_max(input int display, input int front,
                                input int sync, input int back);
    return vt_total(display, front, sync, back) - 1;
  endfunction

  // First position inside the sync pulse.
  function automatic int vt_sync_start(input int display, input int front);
    return display + front;
  endfunction

  // Last position inside the sync pulse (inclusive).
  function automatic int vt_sync_end(input int display, input int front,
                                     input int sync);
    return display + front + sync - 1;
  endfunction

  // True when a maximum position is representable in a w-bit counter.
  function automatic bit vt_fits(input int max_pos, input int w);
    return (w < 31) ? (max_pos < (1 << w)) : 1'b1;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bus: control inputs into the generator and the registered
// position/sync/strobe outputs towards the display path.
interface video_timing_gen_if #(
  parameter int HW  = 9,
  parameter int VW  = 9,
  parameter int FCW = 16
);
  logic           pix_en;
  logic [VW-1:0]  irq_line;
  logic [HW-1:0]  hpos;
  logic [VW-1:0]  vpos;
  logic           hsync;
  logic           vsync;
  logic           display_on;
  logic           hblank;
  logic           vblank;
  logic           line_start;
  logic           frame_start;
  logic           raster_irq;
  logic [FCW-1:0] frame_count;

  modport master (
    input  pix_en, irq_line,
    output hpos, vpos, hsync, vsync, display_on, hblank, vblank,
           line_start, frame_start, raster_irq, frame_count
  );

  modport slave (
    output pix_en, irq_line,
    input  hpos, vpos, hsync, vsync, display_on, hblank, vblank,
           line_start, frame_start, raster_irq, frame_count
  );
endinterface

// File: rtl/video_axis_counter.sv
// One raster axis (horizontal or vertical). Advances when step and wrap_in
// are both high; all outputs are registered and decoded from the position
// being entered, so sync/blank always line up with pos.
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int DISPLAY = 320,
  parameter int FRONT   = 8,
  parameter int SYNC    = 24,
  parameter int BACK    = 8,
  parameter bit POL     = 1'b1,
  parameter int W       = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         wrap_in,
  output logic [W-1:0] pos,
  output logic [W-1:0] pos_d,
  output logic         at_max,
  output logic         sync,
  output logic         blank,
  output logic         entered_zero
);

  localparam int MAX_I = vt_max(DISPLAY, FRONT, SYNC, BACK);

  generate
    if (SYNC < 1) begin : g_bad_sync
      $error("video_axis_counter: SYNC width must be at least 1");
    end
    if (!vt_fits(MAX_I, W)) begin : g_bad_width
      $error("video_axis_counter: W too narrow for TOTAL-1");
    end
  endgenerate

  localparam logic [W-1:0] MAX_V  = W'(MAX_I);
  localparam logic [W-1:0] DISP_V = W'(DISPLAY);
  localparam logic [W-1:0] SS_V   = W'(vt_sync_start(DISPLAY, FRONT));
  localparam logic [W-1:0] SE_V   = W'(vt_sync_end(DISPLAY, FRONT, SYNC));

  logic         adv;
  logic [W-1:0] stepped;

  // Sync level for a given position, honouring polarity.
  function automatic logic sync_lvl(input logic [W-1:0] p);
    return ((p >= SS_V) && (p <= SE_V)) ? POL : ~POL;
  endfunction

  assign adv     = step & wrap_in;
  assign stepped = at_max ? '0 : pos + W'(1);
  // Position this axis will hold after the coming edge; the top level
  // decodes display_on and the raster compare from it.
  assign pos_d   = adv ? stepped : pos;

  // Position register plus registered decodes of the position being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos          <= MAX_V;
      at_max       <= 1'b1;
      sync         <= sync_lvl(MAX_V);
      blank        <= (MAX_V >= DISP_V);
      entered_zero <= 1'b0;
    end else begin
      entered_zero <= adv & at_max;
      pos          <= pos_d;
      at_max       <= (pos_d == MAX_V);
      sync         <= sync_lvl(pos_d);
      blank        <= (pos_d >= DISP_V);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: H and V axis counters plus the frame-level
// registers (display_on, raster interrupt, frame counter).
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_DISPLAY = 320,
  parameter int H_FRONT   = 8,
  parameter int H_SYNC    = 24,
  parameter int H_BACK    = 8,
  parameter int V_DISPLAY = 240,
  parameter int V_FRONT   = 4,
  parameter int V_SYNC    = 3,
  parameter int V_BACK    = 15,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int HW        = 9,
  parameter int VW        = 9,
  parameter int FCW       = 16
) (
  input  logic               clk,
  input  logic               reset,
  video_timing_gen_if.master vt
);

  localparam logic [HW-1:0] HD_V = HW'(H_DISPLAY);
  localparam logic [VW-1:0] VD_V = VW'(V_DISPLAY);

  logic [HW-1:0]  h_pos, h_pos_d;
  logic [VW-1:0]  v_pos, v_pos_d;
  logic           h_at_max, h_sync, h_blank, h_ez;
  logic           v_at_max, v_sync, v_blank, v_ez;
  logic           display_on;
  logic           raster_irq;
  logic [FCW-1:0] frame_count;

  video_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .POL(HSYNC_POL), .W(HW)
  ) u_h (
    .clk(clk), .reset(reset), .step(vt.pix_en), .wrap_in(1'b1),
    .pos(h_pos), .pos_d(h_pos_d), .at_max(h_at_max), .sync(h_sync),
    .blank(h_blank), .entered_zero(h_ez)
  );

  // Vertical axis only moves on the pixel step that wraps the line.
  video_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .POL(VSYNC_POL), .W(VW)
  ) u_v (
    .clk(clk), .reset(reset), .step(vt.pix_en), .wrap_in(h_at_max),
    .pos(v_pos), .pos_d(v_pos_d), .at_max(v_at_max), .sync(v_sync),
    .blank(v_blank), .entered_zero(v_ez)
  );

  // Frame-level registers: visible-area flag, raster interrupt strobe and
  // frame counter, all updated from the position being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      display_on  <= 1'b0;
      raster_irq  <= 1'b0;
      frame_count <= '1;
    end else begin
      display_on <= (h_pos_d < HD_V) && (v_pos_d < VD_V);
      // irq_line is only looked at on an advancing edge, so changes between
      // edges cannot produce a stray pulse.
      raster_irq <= vt.pix_en && (h_pos_d == HD_V) && (v_pos_d == vt.irq_line);
      if (vt.pix_en && h_at_max && v_at_max)
        frame_count <= frame_count + FCW'(1);
    end
  end

  assign vt.hpos        = h_pos;
  assign vt.vpos        = v_pos;
  assign vt.hsync       = h_sync;
  assign vt.vsync       = v_sync;
  assign vt.hblank      = h_blank;
  assign vt.vblank      = v_blank;
  assign vt.display_on  = display_on;
  assign vt.line_start  = h_ez;
  assign vt.frame_start = v_ez;
  assign vt.raster_irq  = raster_irq;
  assign vt.frame_count = frame_count;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen in the small 8/1/2/1 x 4/1/1/1 configuration.
// Two instances share stimulus: positive and negative sync polarity.
module tb_video_timing_gen;
  localparam int HW = 4, VW = 3, FCW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_en = 1'b0;
  logic [VW-1:0] irq_line = 3'd7;

  int n_vec = 0;
  int n_err = 0;

  typedef struct { int h; int v; int fc; } ev_t;
  ev_t q_line[$];
  ev_t q_frame[$];
  ev_t q_irq[$];

  int eh = 11, ev = 6, efc = 15;

  always #5 clk = ~clk;

  video_timing_gen_if #(.HW(HW), .VW(VW), .FCW(FCW)) vp ();
  video_timing_gen_if #(.HW(HW), .VW(VW), .FCW(FCW)) vn ();

  assign vp.pix_en   = pix_en;
  assign vp.irq_line = irq_line;
  assign vn.pix_en   = pix_en;
  assign vn.irq_line = irq_line;

  video_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .HW(HW), .VW(VW), .FCW(FCW)
  ) dut_p (.clk(clk), .reset(rst_n), .vt(vp));

  video_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .HW(HW), .VW(VW), .FCW(FCW)
  ) dut_n (.clk(clk), .reset(rst_n), .vt(vn));

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Level outputs of both instances against the expected position.
  task automatic check_levels();
    logic hs, vs;
    hs = (eh >= 9 && eh <= 10);
    vs = (ev == 5);
    check("hpos", vp.hpos, eh);
    check("vpos", vp.vpos, ev);
    check("hsync_p", vp.hsync, hs);
    check("vsync_p", vp.vsync, vs);
    check("hsync_n", vn.hsync, !hs);
    check("vsync_n", vn.vsync, !vs);
    check("hblank", vp.hblank, eh >= 8);
    check("vblank", vp.vblank, ev >= 4);
    check("display_on", vp.display_on, (eh < 8) && (ev < 4));
    check("frame_count", vp.frame_count, efc);
  endtask

  // One clock: drive pix_en, queue the strobes it must produce, then sample.
  task automatic tick(input logic en);
    pix_en = en;
    if (en) begin
      if (eh == 11) begin
        eh = 0;
        ev = (ev == 6) ? 0 : ev + 1;
      end else begin
        eh++;
      end
      if (eh == 0) q_line.push_back('{h: eh, v: ev, fc: 0});
      if (eh == 0 && ev == 0) begin
        efc = (efc + 1) % 16;
        q_frame.push_back('{h: 0, v: 0, fc: efc});
      end
      if (eh == 8 && ev == int'(irq_line)) q_irq.push_back('{h: 8, v: ev, fc: 0});
    end
    @(negedge clk);
    check_levels();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hpos"}, vp.hpos, 11);
    check({tag, "_vpos"}, vp.vpos, 6);
    check({tag, "_hsync_p"}, vp.hsync, 0);
    check({tag, "_vsync_p"}, vp.vsync, 0);
    check({tag, "_hsync_n"}, vn.hsync, 1);
    check({tag, "_vsync_n"}, vn.vsync, 1);
    check({tag, "_hblank"}, vp.hblank, 1);
    check({tag, "_vblank"}, vp.vblank, 1);
    check({tag, "_display_on"}, vp.display_on, 0);
    check({tag, "_strobes"}, {vp.line_start, vp.frame_start, vp.raster_irq}, 0);
    check({tag, "_frame_count"}, vp.frame_count, 15);
  endtask

  // Monitor: every strobe seen must match the oldest queued expectation.
  always @(negedge clk) begin
    ev_t e;
    if (vp.line_start) begin
      if (q_line.size() == 0) check("line_start_unexpected", 1, 0);
      else begin
        e = q_line.pop_front();
        check("line_start_h", vp.hpos, e.h);
        check("line_start_v", vp.vpos, e.v);
      end
    end
    if (vp.frame_start) begin
      if (q_frame.size() == 0) check("frame_start_unexpected", 1, 0);
      else begin
        e = q_frame.pop_front();
        check("frame_start_h", vp.hpos, e.h);
        check("frame_start_v", vp.vpos, e.v);
        check("frame_start_fc", vp.frame_count, e.fc);
      end
    end
    if (vp.raster_irq) begin
      if (q_irq.size() == 0) check("raster_irq_unexpected", 1, 0);
      else begin
        e = q_irq.pop_front();
        check("raster_irq_h", vp.hpos, e.h);
        check("raster_irq_v", vp.vpos, e.v);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;

    // First frame plus the next frame_start; irq expected at (8,2).
    irq_line = 3'd2;
    repeat (85) tick(1'b1);
    check("second_frame_fc", vp.frame_count, 1);

    // Stuttered pixel enable: strobes must not repeat while held.
    for (int i = 0; i < 40; i++) begin
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
    end

    // irq_line beyond V_MAX never fires.
    irq_line = 3'd7;
    repeat (84) tick(1'b1);

    // Move irq target from line 2 to 3 mid-line 2, before hpos 8.
    irq_line = 3'd2;
    for (int i = 0; i < 200 && !(eh == 3 && ev == 2); i++) tick(1'b1);
    check("reached_3_2", (eh == 3 && ev == 2), 1);
    irq_line = 3'd3;
    repeat (84) tick(1'b1);

    // Run through enough frames for frame_count to wrap 15 -> 0.
    irq_line = 3'd7;
    repeat (16 * 84) tick(1'b1);

    // Reset at (5,3) for one clock.
    for (int i = 0; i < 200 && !(eh == 5 && ev == 3); i++) tick(1'b1);
    check("reached_5_3", (eh == 5 && ev == 3), 1);
    pix_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_hpos", vp.hpos, 11);
    @(negedge clk);
    rst_n = 1'b1;
    eh = 11;
    ev = 6;
    efc = 15;
    check_reset_state("midrst");
    repeat (90) tick(1'b1);

    pix_en = 1'b0;
    @(negedge clk);
    #1;
    check("line_q_empty", q_line.size(), 0);
    check("frame_q_empty", q_frame.size(), 0);
    check("irq_q_empty", q_irq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
